seg14_scan_decoder: RTL and testbench
=====================================

Name: seg14_scan_decoder

Overview:
- Monitor and decoder for the 12-digit, 14-segment multiplexed display bus (one-hot digit select plus segment pattern, one digit per clock).
- Samples the bus, checks the scan order, decodes each segment pattern back to an ASCII code, and streams (position, character) pairs through a small valid/ready FIFO.
- Sits beside the display driver, on the same clock, for on-chip self-check and for readback through the logic analyser/wishbone path.

Parameters:
- DIGITS, 12, number of scanned digit positions; sel width; last index is DIGITS-1.
- FIFO_DEPTH, 4, output character FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, shared with the display driver.
- rst_n  input  1  asynchronous active-low reset.
- sel_in  input  DIGITS  digit select from the display driver; one-hot.
- segm_in  input  14  segment pattern; bit 13 = segment a … bit 0 = last diagonal.
- char_ready  input  1  consumer accepts the FIFO head.
- char_valid  output  1  FIFO not empty.
- char_data  output  8  ASCII code at the FIFO head.
- char_pos  output  4  digit index (0..DIGITS-1) of char_data.
- frame_done  output  1  one-cycle pulse: positions 0..DIGITS-1 accepted in order.
- err_sel  output  1  one-cycle pulse: sel not one-hot, or index out of order.
- err_glyph  output  1  one-cycle pulse: segment pattern not in the glyph table.
- err_ovf  output  1  sticky: character dropped on a full FIFO; cleared only by reset.

Behaviour:
- Reset, asynchronous and active-low: all outputs 0; FIFO empty; FSM = HUNT; sample registers cleared; expected index = 0.
- Stage S (every edge):
  - Register sel_in and segm_in into s_sel and s_segm.
  - Keep the previous s_sel in p_sel.
- A digit event is generated when s_sel != p_sel and s_sel != 0:
  - sel held for several cycles produces one event only.
  - sel = 0 is a blanking interval and produces no event.
- Index = position of the set bit in s_sel. A non-one-hot s_sel (two or more bits set) raises err_sel and forces HUNT, with no push.
- FSM HUNT:
  - Event with index 0: accept it and go to TRACK with expected = 1.
  - Any other event: ignored, with no error.
- FSM TRACK:
  - Event with index == expected: accept; expected++.
  - Accepted index == DIGITS-1: pulse frame_done and set expected = 0; the FSM stays in TRACK.
  - Event with index != expected and index == 0: pulse err_sel, accept it as a new frame start, expected = 1.
  - Event with index != expected and index != 0: pulse err_sel, go to HUNT, no push.
- Accept = decode s_segm and push {index, ascii} into the FIFO.
  - Push, err pulses and frame_done all occur on the edge after the sample edge.
  - Latency: bus value at edge k → char_valid high after edge k+1 (FIFO previously empty).
- Glyph table (segm → ASCII):
  - 11101111000000 → 0x41 'A'.
  - 10011110000000 → 0x45 'E'.
  - 10111101000000 → 0x47 'G'.
  - 00011100000000 → 0x4C 'L'.
  - 01101100101000 → 0x4D 'M'.
  - 01101100100100 → 0x4E 'N'.
  - 11001111000000 → 0x50 'P'.
  - 00000000000000 → 0x20 ' '.
  - Any other pattern → 0x3F '?' with err_glyph pulsed; the character is still pushed.
- FIFO:
  - Pop occurs on char_valid && char_ready.
  - Push and pop on the same edge are both performed, including when full.
  - Push while full with no pop: the character is dropped and err_ovf is set; the FSM and expected index still advance, and frame_done still fires.
- Reset asserted mid-frame clears everything immediately. After release the FSM is in HUNT and ignores events until index 0.

Decomposition:
- Package seg14_pkg holds:
  - DIGITS default;
  - 14-bit glyph constants and their ASCII codes;
  - the function glyph_to_ascii(segm) returning {unknown, ascii};
  - FSM state enum {HUNT, TRACK}.
- One sub-module: seg14_char_fifo (synchronous FIFO, width 12 = pos+ascii, depth FIFO_DEPTH, async active-low reset, push/pop/full/empty).
- Sel check (one-hot test, index encode) is local logic in the top.

Test Plan:
- Clean frame: drive sel one-hot 0..11, one cycle each, with segm for "ALEMAN   GPE"; char_ready = 1 → 12 chars out: 0x41,0x4C,0x45,0x4D,0x41,0x4E,0x20,0x20,0x20,0x47,0x50,0x45 at pos 0..11; frame_done pulses once, aligned with the pos 11 push; no errors.
- Held and blanked scan: each sel value held 3 cycles with sel = 0 between digits → still exactly 12 chars and one frame_done.
- Ordering faults:
  - Start mid-frame at index 5 → nothing output until index 0.
  - sel = 12'h003 → err_sel pulse, HUNT.
  - Jump 0,1,3 → err_sel at 3, HUNT.
  - Jump 0,1,0 → err_sel, new frame with pos 0 pushed.
- Unknown glyph: segm = 14'h3FFF at index 2 → char 0x3F at pos 2, err_glyph one pulse, frame still completes.
- Backpressure: char_ready = 0 through a full frame (FIFO_DEPTH = 4) → first 4 chars (pos 0..3) retained, err_ovf set and held; raise char_ready → the 4 chars drain in order.
- Reset mid-frame: assert rst_n = 0 after pos 6, then release mid-scan → all outputs 0, FIFO empty, next output is pos 0 of the following frame.

Source files
------------

// File: rtl/seg14_pkg.sv
// Shared definitions for the 14-segment scan decoder: sizing default,
// glyph table, glyph decode function and the scan-tracking FSM states.
package seg14_pkg;

   localparam int DIGITS_DEFAULT = 12;

   // Segment patterns, bit 13 = segment a ... bit 0 = last diagonal
   localparam logic [13:0] GLYPH_A     = 14'b11101111000000;
   localparam logic [13:0] GLYPH_E     = 14'b10011110000000;
   localparam logic [13:0] GLYPH_G     = 14'b10111101000000;
   localparam logic [13:0] GLYPH_L     = 14'b00011100000000;
   localparam logic [13:0] GLYPH_M     = 14'b01101100101000;
   localparam logic [13:0] GLYPH_N     = 14'b01101100100100;
   localparam logic [13:0] GLYPH_P     = 14'b11001111000000;
   localparam logic [13:0] GLYPH_SPACE = 14'b00000000000000;

   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_E     = 8'h45;
   localparam logic [7:0] ASCII_G     = 8'h47;
   localparam logic [7:0] ASCII_L     = 8'h4C;
   localparam logic [7:0] ASCII_M     = 8'h4D;
   localparam logic [7:0] ASCII_N     = 8'h4E;
   localparam logic [7:0] ASCII_P     = 8'h50;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_UNK   = 8'h3F;

   typedef enum logic {
      HUNT  = 1'b0,
      TRACK = 1'b1
   } seg14_state_e;

   // Returns {unknown, ascii}; unknown patterns map to '?'
   function automatic logic [8:0] glyph_to_ascii(input logic [13:0] segm);
      logic [8:0] r;
      case (segm)
         GLYPH_A:     r = {1'b0, ASCII_A};
         GLYPH_E:     r = {1'b0, ASCII_E};
         GLYPH_G:     r = {1'b0, ASCII_G};
         GLYPH_L:     r = {1'b0, ASCII_L};
         GLYPH_M:     r = {1'b0, ASCII_M};
         GLYPH_N:     r = {1'b0, ASCII_N};
         GLYPH_P:     r = {1'b0, ASCII_P};
         GLYPH_SPACE: r = {1'b0, ASCII_SPACE};
         default:     r = {1'b1, ASCII_UNK};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg14_char_fifo.sv
// Small synchronous FIFO for decoded {position, ascii} entries.
// A push while full is only taken if a pop happens on the same edge.
module seg14_char_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_wr;
   logic             do_rd;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_wr     = push && (!full || pop);
   assign do_rd     = pop && !empty;
   assign head_data = mem[rd_ptr[AW-1:0]];

   // Storage and pointers; storage is cleared so the head reads 0 after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/seg14_scan_decoder.sv
// Monitor/decoder for the multiplexed 14-segment display bus. Samples the
// bus, tracks the digit scan order, decodes glyphs to ASCII and queues
// (position, character) pairs for a consumer.
//
// Output handshake: char_valid is high whenever the FIFO holds an entry and
// char_data/char_pos show that entry; the entry is consumed on every clock
// edge where char_valid && char_ready. char_valid does not depend on
// char_ready, and the head does not change until it is consumed.
module seg14_scan_decoder
   import seg14_pkg::*;
#(
   parameter int DIGITS     = DIGITS_DEFAULT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DIGITS-1:0] sel_in,
   input  logic [13:0]       segm_in,
   input  logic              char_ready,
   output logic              char_valid,
   output logic [7:0]        char_data,
   output logic [3:0]        char_pos,
   output logic              frame_done,
   output logic              err_sel,
   output logic              err_glyph,
   output logic              err_ovf
);

   // Sample stage
   logic [DIGITS-1:0] s_sel;
   logic [DIGITS-1:0] p_sel;
   logic [13:0]       s_segm;

   // Scan tracking (state_q is the FSM state for checkers to bind to)
   seg14_state_e state_q, state_d;
   logic [3:0]   exp_idx_q, exp_idx_d;

   logic        dig_event;
   logic        s_onehot;
   logic [3:0]  s_idx;
   logic [8:0]  glyph;
   logic        accept;
   logic        err_sel_d;
   logic        frame_done_d;

   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_pop;
   logic [11:0] fifo_head;

   // Register the bus and keep the previous select for change detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_sel  <= '0;
         p_sel  <= '0;
         s_segm <= '0;
      end else begin
         s_sel  <= sel_in;
         p_sel  <= s_sel;
         s_segm <= segm_in;
      end
   end

   // A held select yields one event; an all-zero select is blanking
   assign dig_event = (s_sel != p_sel) && (s_sel != '0);
   assign s_onehot  = ((s_sel & (s_sel - DIGITS'(1))) == '0);
   assign glyph     = glyph_to_ascii(s_segm);

   // Encode the set bit of the sampled select into a digit index
   always_comb begin
      s_idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (s_sel[i]) begin
            s_idx = s_idx | 4'(i);
         end
      end
   end

   // Scan order FSM state and expected-index registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HUNT;
         exp_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         exp_idx_q <= exp_idx_d;
      end
   end

   // Next state: accept in-order digits, resync on index 0, else fall to HUNT
   always_comb begin
      state_d      = state_q;
      exp_idx_d    = exp_idx_q;
      accept       = 1'b0;
      err_sel_d    = 1'b0;
      frame_done_d = 1'b0;
      if (dig_event) begin
         if (!s_onehot) begin
            err_sel_d = 1'b1;
            state_d   = HUNT;
            exp_idx_d = '0;
         end else begin
            case (state_q)
               HUNT: begin
                  if (s_idx == 4'd0) begin
                     accept    = 1'b1;
                     state_d   = TRACK;
                     exp_idx_d = 4'd1;
                  end
               end
               TRACK: begin
                  if (s_idx == exp_idx_q) begin
                     accept = 1'b1;
                     if (s_idx == 4'(DIGITS-1)) begin
                        frame_done_d = 1'b1;
                        exp_idx_d    = '0;
                     end else begin
                        exp_idx_d = exp_idx_q + 4'd1;
                     end
                  end else if (s_idx == 4'd0) begin
                     err_sel_d = 1'b1;
                     accept    = 1'b1;
                     exp_idx_d = 4'd1;
                  end else begin
                     err_sel_d = 1'b1;
                     state_d   = HUNT;
                     exp_idx_d = '0;
                  end
               end
               default: begin
                  state_d   = HUNT;
                  exp_idx_d = '0;
               end
            endcase
         end
      end
   end

   // Status pulses and the sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done <= 1'b0;
         err_sel    <= 1'b0;
         err_glyph  <= 1'b0;
         err_ovf    <= 1'b0;
      end else begin
         frame_done <= frame_done_d;
         err_sel    <= err_sel_d;
         err_glyph  <= accept && glyph[8];
         if (accept && fifo_full && !fifo_pop) begin
            err_ovf <= 1'b1;
         end
      end
   end

   assign fifo_pop   = char_valid && char_ready;
   assign char_valid = !fifo_empty;
   assign char_pos   = fifo_head[11:8];
   assign char_data  = fifo_head[7:0];

   seg14_char_fifo #(
      .WIDTH (12),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept),
      .push_data ({s_idx, glyph[7:0]}),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// Directed bench for seg14_scan_decoder: clean, held/blanked, out-of-order,
// unknown glyph, backpressure and mid-frame reset scans.
module tb_seg14_scan_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] sel_in;
   logic [13:0] segm_in;
   logic        char_ready;
   logic        char_valid;
   logic [7:0]  char_data;
   logic [3:0]  char_pos;
   logic        frame_done;
   logic        err_sel;
   logic        err_glyph;
   logic        err_ovf;

   int tests = 0;
   int fails = 0;

   // Hand-entered glyph table
   localparam logic [13:0] T_A   = 14'b11101111000000;
   localparam logic [13:0] T_E   = 14'b10011110000000;
   localparam logic [13:0] T_G   = 14'b10111101000000;
   localparam logic [13:0] T_L   = 14'b00011100000000;
   localparam logic [13:0] T_M   = 14'b01101100101000;
   localparam logic [13:0] T_N   = 14'b01101100100100;
   localparam logic [13:0] T_P   = 14'b11001111000000;

   // "ALEMAN   GPE"
   logic [7:0] txt [12] = '{8'h41, 8'h4C, 8'h45, 8'h4D, 8'h41, 8'h4E,
                            8'h20, 8'h20, 8'h20, 8'h47, 8'h50, 8'h45};

   // Clock
   always #5 clk = ~clk;

   seg14_scan_decoder #(.DIGITS(12), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sel_in     (sel_in),
      .segm_in    (segm_in),
      .char_ready (char_ready),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_pos   (char_pos),
      .frame_done (frame_done),
      .err_sel    (err_sel),
      .err_glyph  (err_glyph),
      .err_ovf    (err_ovf)
   );

   // Collector: records consumed entries and counts pulses, sampled mid-cycle
   logic [11:0] got_mem [256];
   int          got_n  = 0;
   int          fd_cnt = 0;
   int          es_cnt = 0;
   int          eg_cnt = 0;
   logic [3:0]  fd_pos = '0;

   always @(negedge clk) begin
      if (char_valid && char_ready) begin
         got_mem[got_n[7:0]] = {char_pos, char_data};
         got_n = got_n + 1;
      end
      if (frame_done) begin
         fd_cnt = fd_cnt + 1;
         fd_pos = char_pos;
      end
      if (err_sel)   es_cnt = es_cnt + 1;
      if (err_glyph) eg_cnt = eg_cnt + 1;
   end

   function automatic logic [13:0] seg_of(input logic [7:0] ch);
      case (ch)
         8'h41:   return T_A;
         8'h45:   return T_E;
         8'h47:   return T_G;
         8'h4C:   return T_L;
         8'h4D:   return T_M;
         8'h4E:   return T_N;
         8'h50:   return T_P;
         default: return 14'h0000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Driver: apply bus value just after an edge, return just after the next edge
   task automatic step(input logic [11:0] sel, input logic [13:0] segm);
      sel_in  = sel;
      segm_in = segm;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(12'h000, 14'h0000);
   endtask

   task automatic digit(input int idx);
      step(12'(1) << idx, seg_of(txt[idx]));
   endtask

   task automatic send_frame(input int bad_pos, input logic [13:0] bad_seg,
                             input int hold, input bit blank);
      for (int i = 0; i < 12; i++) begin
         for (int h = 0; h < hold; h++) begin
            step(12'(1) << i, (i == bad_pos) ? bad_seg : seg_of(txt[i]));
         end
         if (blank) step(12'h000, 14'h0000);
      end
   endtask

   task automatic check_got(input int slot, input int pos, input logic [7:0] ch);
      check("chr_pos",  32'(got_mem[slot[7:0]][11:8]), 32'(pos));
      check("chr_data", 32'(got_mem[slot[7:0]][7:0]),  32'(ch));
   endtask

   task automatic check_frame(input int base, input int bad_pos, input logic [7:0] bad_ch);
      for (int i = 0; i < 12; i++) begin
         check_got(base + i, i, (i == bad_pos) ? bad_ch : txt[i]);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, 32'(char_valid), 32'd0);
      check({tag, "_data"},  32'(char_data),  32'd0);
      check({tag, "_pos"},   32'(char_pos),   32'd0);
      check({tag, "_fd"},    32'(frame_done), 32'd0);
      check({tag, "_esel"},  32'(err_sel),    32'd0);
      check({tag, "_egly"},  32'(err_glyph),  32'd0);
      check({tag, "_eovf"},  32'(err_ovf),    32'd0);
   endtask

   int base, fd0, es0, eg0;

   initial begin
      // Reset
      rst_n      = 1'b0;
      sel_in     = '0;
      segm_in    = '0;
      char_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("rst");
      rst_n = 1'b1;
      idle(2);
      check_idle_outputs("post_rst");

      // Clean frame with first-character latency
      base = got_n; fd0 = fd_cnt; es0 = es_cnt; eg0 = eg_cnt;
      digit(0);
      check("lat_edge_k", 32'(char_valid), 32'd0);
      digit(1);
      check("lat_valid", 32'(char_valid), 32'd1);
      check("lat_pos",   32'(char_pos),   32'd0);
      check("lat_data",  32'(char_data),  32'h41);
      for (int i = 2; i < 12; i++) digit(i);
      idle(4);
      check("clean_cnt", 32'(got_n - base), 32'd12);
      check_frame(base, 99, 8'h00);
      check("clean_fd",     32'(fd_cnt - fd0), 32'd1);
      check("clean_fd_pos", 32'(fd_pos),       32'd11);
      check("clean_esel",   32'(es_cnt - es0), 32'd0);
      check("clean_egly",   32'(eg_cnt - eg0), 32'd0);
      check("clean_eovf",   32'(err_ovf),      32'd0);

      // Held and blanked scan
      base = got_n; fd0 = fd_cnt; es0 = es_cnt;
      send_frame(99, 14'h0000, 3, 1'b1);
      idle(4);
      check("held_cnt", 32'(got_n - base), 32'd12);
      check_frame(base, 99, 8'h00);
      check("held_fd",   32'(fd_cnt - fd0), 32'd1);
      check("held_esel", 32'(es_cnt - es0), 32'd0);

      // Ordering faults
      base = got_n; fd0 = fd_cnt; es0 = es_cnt;
      step(12'h003, T_A);
      idle(1);
      digit(5); digit(6); digit(7);
      idle(2);
      check("hunt_cnt",  32'(got_n - base), 32'd0);
      check("hunt_esel", 32'(es_cnt - es0), 32'd1);
      digit(0); digit(1); digit(3);
      idle(2);
      check("jump3_cnt",  32'(got_n - base), 32'd2);
      check("jump3_esel", 32'(es_cnt - es0), 32'd2);
      digit(0); digit(1); digit(0);
      for (int i = 1; i < 12; i++) digit(i);
      idle(4);
      check("order_cnt",  32'(got_n - base), 32'd16);
      check("order_esel", 32'(es_cnt - es0), 32'd3);
      check("order_fd",   32'(fd_cnt - fd0), 32'd1);
      check_got(base + 0, 0, 8'h41);
      check_got(base + 1, 1, 8'h4C);
      check_got(base + 2, 0, 8'h41);
      check_got(base + 3, 1, 8'h4C);
      check_frame(base + 4, 99, 8'h00);

      // Unknown glyph at position 2
      base = got_n; fd0 = fd_cnt; es0 = es_cnt; eg0 = eg_cnt;
      send_frame(2, 14'h3FFF, 1, 1'b0);
      idle(4);
      check("unk_cnt", 32'(got_n - base), 32'd12);
      check_frame(base, 2, 8'h3F);
      check("unk_egly", 32'(eg_cnt - eg0), 32'd1);
      check("unk_fd",   32'(fd_cnt - fd0), 32'd1);
      check("unk_esel", 32'(es_cnt - es0), 32'd0);

      // Backpressure through a whole frame
      char_ready = 1'b0;
      base = got_n; fd0 = fd_cnt;
      send_frame(99, 14'h0000, 1, 1'b0);
      idle(3);
      check("bp_cnt",   32'(got_n - base), 32'd0);
      check("bp_valid", 32'(char_valid),   32'd1);
      check("bp_pos",   32'(char_pos),     32'd0);
      check("bp_eovf",  32'(err_ovf),      32'd1);
      check("bp_fd",    32'(fd_cnt - fd0), 32'd1);
      char_ready = 1'b1;
      idle(6);
      check("drain_cnt", 32'(got_n - base), 32'd4);
      for (int i = 0; i < 4; i++) check_got(base + i, i, txt[i]);
      check("drain_valid", 32'(char_valid), 32'd0);
      check("drain_eovf",  32'(err_ovf),    32'd1);

      // Reset in the middle of a frame, released mid-scan
      base = got_n;
      for (int i = 0; i < 7; i++) digit(i);
      idle(2);
      check("pre_rst_cnt", 32'(got_n - base), 32'd7);
      digit(7);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("mid_rst");
      digit(8);
      digit(9);
      rst_n = 1'b1;
      fd0 = fd_cnt; es0 = es_cnt;
      digit(10);
      digit(11);
      idle(2);
      check("rel_cnt", 32'(got_n - base), 32'd7);
      send_frame(99, 14'h0000, 1, 1'b0);
      idle(4);
      check("rel_frame_cnt", 32'(got_n - base), 32'd19);
      check_frame(base + 7, 99, 8'h00);
      check("rel_fd",   32'(fd_cnt - fd0), 32'd1);
      check("rel_esel", 32'(es_cnt - es0), 32'd0);
      check("rel_eovf", 32'(err_ovf),      32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
